ball_motion: RTL and testbench



---
 rtl/ball_pkg.sv | 26 ++
 rtl/ball_motion_axis_step.sv | 41 ++++
 rtl/ball_motion.sv | 181 ++++++++++++++++++
 tb/tb_ball_motion.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ball_pkg.sv
// Shared types and playfield bounds for the ball motion engine.
// Bounds are ball-centre limits in the display's x_cnt/y_cnt coordinate system.
package ball_pkg;

    localparam int N_BALLS = 5;
    localparam int X_MIN   = 66;
    localparam int X_MAX   = 825;
    localparam int Y_MIN   = 43;
    localparam int Y_MAX   = 482;

    typedef logic [9:0]        coord_x_t;
    typedef logic [8:0]        coord_y_t;
    typedef logic signed [4:0] vel_t;

    typedef enum logic [1:0] {
        IDLE,
        UPDATE,
        COMMIT
    } state_t;

    // -16 has no positive counterpart in 5 bits, so it is pulled in to -15
    function automatic vel_t sat_vel(input vel_t v);
        return (v == vel_t'(5'b10000)) ? vel_t'(5'b10001) : v;
    endfunction

endpackage

// File: rtl/ball_motion_axis_step.sv
// One-axis move-and-reflect step: adds a signed velocity to a coordinate and
// mirrors the result about the wall it crossed, negating the velocity.
module ball_axis_step
    import ball_pkg::*;
#(
    parameter int W   = 10,
    parameter int MIN = 66,
    parameter int MAX = 825
) (
    input  logic [W-1:0] i_p,
    input  vel_t         i_v,
    output logic [W-1:0] o_p,
    output vel_t         o_v
);

    localparam logic signed [11:0] L_MIN  = 12'(MIN);
    localparam logic signed [11:0] L_MAX  = 12'(MAX);
    localparam logic signed [11:0] L_MIN2 = 12'(2 * MIN);
    localparam logic signed [11:0] L_MAX2 = 12'(2 * MAX);

    logic signed [11:0] w_n;
    logic signed [11:0] w_lo;
    logic signed [11:0] w_hi;

    assign w_n  = $signed({{(12 - W){1'b0}}, i_p}) + $signed({{7{i_v[4]}}, i_v});
    assign w_lo = L_MIN2 - w_n;
    assign w_hi = L_MAX2 - w_n;

    always_comb begin
        o_p = w_n[W-1:0];
        o_v = i_v;
        if (w_n < L_MIN) begin
            o_p = w_lo[W-1:0];
            o_v = -i_v;
        end else if (w_n > L_MAX) begin
            o_p = w_hi[W-1:0];
            o_v = -i_v;
        end
    end

endmodule

// File: rtl/ball_motion.sv
// Per-frame position engine: steps one ball per cycle after end-of-frame, then
// commits all ten coordinates together so the display never sees a mixed frame.
module ball_motion #(
    parameter int N_BALLS = 5,
    parameter int X_MIN   = 66,
    parameter int X_MAX   = 825,
    parameter int Y_MIN   = 43,
    parameter int Y_MAX   = 482
) (
    input  logic       iCLK,
    input  logic       iRST_n,
    input  logic       iEnd_Frame,
    input  logic       iEnable,
    input  logic       iWR,
    input  logic [2:0] iWR_IDX,
    input  logic [9:0] iWR_X,
    input  logic [8:0] iWR_Y,
    input  logic [4:0] iWR_VX,
    input  logic [4:0] iWR_VY,
    output logic [9:0] oX1,
    output logic [9:0] oX2,
    output logic [9:0] oX3,
    output logic [9:0] oX4,
    output logic [9:0] oX5,
    output logic [8:0] oY1,
    output logic [8:0] oY2,
    output logic [8:0] oY3,
    output logic [8:0] oY4,
    output logic [8:0] oY5,
    output logic       oBusy,
    output logic       oUpdate_Done
);

    import ball_pkg::*;

    state_t     r_state;
    state_t     w_state_next;
    logic [2:0] r_idx;
    logic [2:0] w_idx_next;
    logic       r_busy;
    logic       r_done;

    coord_x_t w_wx [N_BALLS];
    coord_y_t w_wy [N_BALLS];
    vel_t     w_vx [N_BALLS];
    vel_t     w_vy [N_BALLS];
    coord_x_t w_ox [N_BALLS];
    coord_y_t w_oy [N_BALLS];

    coord_x_t w_step_x;
    coord_y_t w_step_y;
    vel_t     w_step_vx;
    vel_t     w_step_vy;

    logic     w_wr_ok;
    coord_x_t w_wr_x;
    coord_y_t w_wr_y;
    vel_t     w_wr_vx;
    vel_t     w_wr_vy;

    // Writes are only taken in IDLE, so they never race the update sweep
    assign w_wr_ok = iWR && !r_busy && (iWR_IDX < 3'(N_BALLS));
    assign w_wr_x  = (iWR_X < 10'(X_MIN)) ? 10'(X_MIN) :
                     (iWR_X > 10'(X_MAX)) ? 10'(X_MAX) : iWR_X;
    assign w_wr_y  = (iWR_Y < 9'(Y_MIN)) ? 9'(Y_MIN) :
                     (iWR_Y > 9'(Y_MAX)) ? 9'(Y_MAX) : iWR_Y;
    assign w_wr_vx = sat_vel(vel_t'(iWR_VX));
    assign w_wr_vy = sat_vel(vel_t'(iWR_VY));

    ball_axis_step #(.W(10), .MIN(X_MIN), .MAX(X_MAX)) u_step_x (
        .i_p (w_wx[r_idx]),
        .i_v (w_vx[r_idx]),
        .o_p (w_step_x),
        .o_v (w_step_vx)
    );

    ball_axis_step #(.W(9), .MIN(Y_MIN), .MAX(Y_MAX)) u_step_y (
        .i_p (w_wy[r_idx]),
        .i_v (w_vy[r_idx]),
        .o_p (w_step_y),
        .o_v (w_step_vy)
    );

    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        case (r_state)
            IDLE: begin
                if (iEnable && iEnd_Frame) begin
                    w_state_next = UPDATE;
                    w_idx_next   = 3'd0;
                end
            end
            UPDATE: begin
                if (r_idx == 3'(N_BALLS - 1)) begin
                    w_state_next = COMMIT;
                end else begin
                    w_idx_next = r_idx + 3'd1;
                end
            end
            COMMIT:  w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_state <= IDLE;
            r_idx   <= 3'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
            r_busy  <= (w_state_next != IDLE);
            r_done  <= (r_state == COMMIT);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_BALLS; gi++) begin : g_ball
            localparam coord_x_t RST_X = coord_x_t'(146 + 150 * gi);
            localparam coord_y_t RST_Y = coord_y_t'(262);

            coord_x_t r_wx;
            coord_y_t r_wy;
            vel_t     r_vx;
            vel_t     r_vy;
            coord_x_t r_ox;
            coord_y_t r_oy;

            always_ff @(posedge iCLK or negedge iRST_n) begin
                if (!iRST_n) begin
                    r_wx <= RST_X;
                    r_wy <= RST_Y;
                    r_vx <= '0;
                    r_vy <= '0;
                    r_ox <= RST_X;
                    r_oy <= RST_Y;
                end else if (w_wr_ok && (iWR_IDX == 3'(gi))) begin
                    r_wx <= w_wr_x;
                    r_wy <= w_wr_y;
                    r_vx <= w_wr_vx;
                    r_vy <= w_wr_vy;
                    r_ox <= w_wr_x;
                    r_oy <= w_wr_y;
                end else if ((r_state == UPDATE) && (r_idx == 3'(gi))) begin
                    r_wx <= w_step_x;
                    r_wy <= w_step_y;
                    r_vx <= w_step_vx;
                    r_vy <= w_step_vy;
                end else if (r_state == COMMIT) begin
                    r_ox <= r_wx;
                    r_oy <= r_wy;
                end
            end

            assign w_wx[gi] = r_wx;
            assign w_wy[gi] = r_wy;
            assign w_vx[gi] = r_vx;
            assign w_vy[gi] = r_vy;
            assign w_ox[gi] = r_ox;
            assign w_oy[gi] = r_oy;
        end
    endgenerate

    assign oX1          = w_ox[0];
    assign oX2          = w_ox[1];
    assign oX3          = w_ox[2];
    assign oX4          = w_ox[3];
    assign oX5          = w_ox[4];
    assign oY1          = w_oy[0];
    assign oY2          = w_oy[1];
    assign oY3          = w_oy[2];
    assign oY4          = w_oy[3];
    assign oY5          = w_oy[4];
    assign oBusy        = r_busy;
    assign oUpdate_Done = r_done;

endmodule

// File: tb/tb_ball_motion.sv
// Self-checking bench for ball_motion: table of single-ball write+frame vectors
// plus hand-written sequences for the multi-cycle corner cases.
module tb_ball_motion;

    logic       iCLK = 1'b0;
    logic       iRST_n = 1'b0;
    logic       iEnd_Frame = 1'b0;
    logic       iEnable = 1'b1;
    logic       iWR = 1'b0;
    logic [2:0] iWR_IDX = '0;
    logic [9:0] iWR_X = '0;
    logic [8:0] iWR_Y = '0;
    logic [4:0] iWR_VX = '0;
    logic [4:0] iWR_VY = '0;
    logic [9:0] oX1, oX2, oX3, oX4, oX5;
    logic [8:0] oY1, oY2, oY3, oY4, oY5;
    logic       oBusy;
    logic       oUpdate_Done;

    ball_motion dut (
        .iCLK         (iCLK),
        .iRST_n       (iRST_n),
        .iEnd_Frame   (iEnd_Frame),
        .iEnable      (iEnable),
        .iWR          (iWR),
        .iWR_IDX      (iWR_IDX),
        .iWR_X        (iWR_X),
        .iWR_Y        (iWR_Y),
        .iWR_VX       (iWR_VX),
        .iWR_VY       (iWR_VY),
        .oX1          (oX1),
        .oX2          (oX2),
        .oX3          (oX3),
        .oX4          (oX4),
        .oX5          (oX5),
        .oY1          (oY1),
        .oY2          (oY2),
        .oY3          (oY3),
        .oY4          (oY4),
        .oY5          (oY5),
        .oBusy        (oBusy),
        .oUpdate_Done (oUpdate_Done)
    );

    always #5 iCLK = ~iCLK;

    typedef struct packed {
        logic [4:0][9:0] x;
        logic [4:0][8:0] y;
    } snap_t;

    typedef struct {
        int idx, x, y, vx, vy;
        int cx, cy;
        int ex, ey;
    } vec_t;

    int    n_tests = 0;
    int    n_fail  = 0;
    snap_t sb[$];
    vec_t  vt[8];

    function automatic snap_t rst_snap();
        snap_t s;
        for (int i = 0; i < 5; i++) begin
            s.x[i] = 10'(146 + 150 * i);
            s.y[i] = 9'd262;
        end
        return s;
    endfunction

    function automatic snap_t dut_snap();
        snap_t s;
        s.x[0] = oX1; s.x[1] = oX2; s.x[2] = oX3; s.x[3] = oX4; s.x[4] = oX5;
        s.y[0] = oY1; s.y[1] = oY2; s.y[2] = oY3; s.y[3] = oY4; s.y[4] = oY5;
        return s;
    endfunction

    task automatic check1(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic check_snap(input string name, input snap_t exp);
        snap_t got;
        int    errs;
        got  = dut_snap();
        errs = 0;
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if (got.x[i] !== exp.x[i]) begin
                n_fail++; errs++;
                $display("FAIL %s oX%0d: got %0d expected %0d", name, i + 1, got.x[i], exp.x[i]);
            end
            n_tests++;
            if (got.y[i] !== exp.y[i]) begin
                n_fail++; errs++;
                $display("FAIL %s oY%0d: got %0d expected %0d", name, i + 1, got.y[i], exp.y[i]);
            end
        end
        $display("[TB] %s: 10 outputs compared, %0d wrong", name, errs);
    endtask

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic do_reset();
        iWR        = 1'b0;
        iEnd_Frame = 1'b0;
        iRST_n     = 1'b0;
        tick();
        tick();
        iRST_n = 1'b1;
        tick();
    endtask

    task automatic do_write(input int idx, input int x, input int y, input int vx, input int vy);
        iWR     = 1'b1;
        iWR_IDX = 3'(idx);
        iWR_X   = 10'(x);
        iWR_Y   = 9'(y);
        iWR_VX  = 5'(vx);
        iWR_VY  = 5'(vy);
        tick();
        iWR = 1'b0;
    endtask

    // Called at some cycle after t0 (start = cycles already elapsed since t0)
    task automatic wait_commit(input string name, input int start);
        int cyc;
        bit seen;
        snap_t e;
        cyc  = start;
        seen = 1'b0;
        check1({name, " busy during update"}, int'(oBusy), 1);
        while (!seen && cyc < 20) begin
            if (oUpdate_Done) seen = 1'b1;
            else begin
                tick();
                cyc++;
            end
        end
        check1({name, " commit latency"}, cyc, 6);
        if (sb.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL %s: scoreboard empty at commit", name);
        end else begin
            e = sb.pop_front();
            if (seen) check_snap(name, e);
        end
        check1({name, " busy at commit"}, int'(oBusy), 0);
        tick();
        check1({name, " done pulse width"}, int'(oUpdate_Done), 0);
        check1({name, " busy after commit"}, int'(oBusy), 0);
    endtask

    task automatic frame(input string name, input snap_t exp);
        sb.push_back(exp);
        iEnd_Frame = 1'b1;
        tick();
        iEnd_Frame = 1'b0;
        wait_commit(name, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global timeout");
        $fatal(1);
    end

    initial begin
        snap_t s;
        bit    ok;

        //           idx  x    y    vx   vy   cx   cy   ex   ey
        vt[0] = '{0, 400, 200,   5,  -3, 400, 200, 405, 197};
        vt[1] = '{2, 820, 262,  10,   0, 820, 262, 820, 262};
        vt[2] = '{4, 746,  45,   0, -16, 746,  45, 746,  56};
        vt[3] = '{1,  66,  43,  -1,  -1,  66,  43,  67,  44};
        vt[4] = '{3, 825, 482,   0,   0, 825, 482, 825, 482};
        vt[5] = '{1,1000, 500,   0,   0, 825, 482, 825, 482};
        vt[6] = '{0,  10,   5,  15,  15,  66,  43,  81,  58};
        vt[7] = '{3, 811, 470,  14,  12, 811, 470, 825, 482};

        for (int i = 0; i < 8; i++) begin
            do_reset();
            check_snap($sformatf("vec%0d reset", i), rst_snap());
            check1($sformatf("vec%0d reset busy", i), int'(oBusy), 0);
            do_write(vt[i].idx, vt[i].x, vt[i].y, vt[i].vx, vt[i].vy);
            s = rst_snap();
            s.x[vt[i].idx] = 10'(vt[i].cx);
            s.y[vt[i].idx] = 9'(vt[i].cy);
            check_snap($sformatf("vec%0d write", i), s);
            s.x[vt[i].idx] = 10'(vt[i].ex);
            s.y[vt[i].idx] = 9'(vt[i].ey);
            frame($sformatf("vec%0d frame", i), s);
        end

        // Second frame after a wall bounce keeps the negated velocity
        do_reset();
        do_write(2, 820, 262, 10, 0);
        s = rst_snap(); s.x[2] = 10'd820;
        frame("bounce f1", s);
        s.x[2] = 10'd810;
        frame("bounce f2", s);

        // Write and end-of-frame pulse mid-update are both dropped
        do_reset();
        do_write(0, 400, 200, 5, -3);
        s = rst_snap(); s.x[0] = 10'd405; s.y[0] = 9'd197;
        sb.push_back(s);
        iEnd_Frame = 1'b1;
        tick();
        iEnd_Frame = 1'b0;
        tick();
        tick();
        iWR = 1'b1; iWR_IDX = 3'd0; iWR_X = 10'd100; iWR_Y = 9'd100;
        iWR_VX = 5'd0; iWR_VY = 5'd0; iEnd_Frame = 1'b1;
        tick();
        iWR = 1'b0; iEnd_Frame = 1'b0;
        wait_commit("busy write", 3);
        s.x[0] = 10'd410; s.y[0] = 9'd194;
        frame("busy write next", s);

        // Write coincident with end-of-frame: written values are stepped
        do_reset();
        iWR = 1'b1; iWR_IDX = 3'd0; iWR_X = 10'd300; iWR_Y = 9'd300;
        iWR_VX = 5'(-7); iWR_VY = 5'd7; iEnd_Frame = 1'b1;
        s = rst_snap(); s.x[0] = 10'd293; s.y[0] = 9'd307;
        sb.push_back(s);
        tick();
        iWR = 1'b0; iEnd_Frame = 1'b0;
        wait_commit("write+frame", 0);

        // Out-of-range ball index is ignored
        do_reset();
        do_write(5, 400, 200, 5, 5);
        do_write(7, 400, 200, 5, 5);
        check_snap("idx>=5 write", rst_snap());

        // Motion disabled: pulses ignored
        do_reset();
        do_write(0, 400, 200, 5, -3);
        iEnable = 1'b0;
        ok = 1'b1;
        for (int k = 0; k < 12; k++) begin
            iEnd_Frame = (k % 3 == 0);
            tick();
            if (oBusy || oUpdate_Done) ok = 1'b0;
        end
        iEnd_Frame = 1'b0;
        iEnable = 1'b1;
        check1("disabled stays idle", int'(ok), 1);
        s = rst_snap(); s.x[0] = 10'd400; s.y[0] = 9'd200;
        check_snap("disabled no move", s);
        s.x[0] = 10'd405; s.y[0] = 9'd197;
        frame("re-enabled frame", s);

        // Reset asserted at t3 restores everything with no commit
        do_reset();
        do_write(0, 400, 200, 5, -3);
        iEnd_Frame = 1'b1;
        tick();
        iEnd_Frame = 1'b0;
        tick(); tick(); tick();
        iRST_n = 1'b0;
        #1;
        check_snap("reset mid-update", rst_snap());
        check1("reset mid-update busy", int'(oBusy), 0);
        tick();
        iRST_n = 1'b1;
        ok = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (oUpdate_Done || oBusy) ok = 1'b0;
        end
        check1("no commit after reset", int'(ok), 1);
        check_snap("after mid-update reset", rst_snap());
        frame("post-reset frame", rst_snap());

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
